// File: rtl/inst_fetch32_if.sv
// Fetch-unit bus: execute redirect, instruction-memory request/response, decode handoff.
// The master modport is the fetch unit; the slave modport is its environment.
interface inst_fetch32_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ack;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ack, mem_rsp_valid, mem_rsp_data, inst_ready,
        output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ack, mem_rsp_valid, mem_rsp_data, inst_ready,
        input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/inst_fetch32.sv
// Instruction fetch front end: credit-limited fetch, prefetch FIFO, redirect flush/drain.
// Define FETCH_PERF_EN to add saturating stall/flush performance counters.
module inst_fetch32 #(
    parameter int unsigned DEPTH        = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_fetch32_if.master        fetch_bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] USED_MAX = (CNT_W + 1)'(DEPTH);

    typedef enum logic [0:0] {StRun, StDrain} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_head_pc;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   w_out_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [31:0]        r_fifo [DEPTH];

    logic [CNT_W:0]     w_used;
    logic               w_req;
    logic               w_ack;
    logic               w_rsp;
    logic               w_push;
    logic               w_pop;

    // Credit counts only registered state, so a pop frees its slot from the next cycle.
    assign w_used = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req  = reset && (r_state == StRun) && (w_used < USED_MAX) && !fetch_bus.redirect_valid;
    assign w_ack  = w_req && fetch_bus.mem_req_ack;
    // Guard against underflow from untracked responses after a reset.
    assign w_rsp  = fetch_bus.mem_rsp_valid && (r_outstanding != '0);
    assign w_push = w_rsp && (r_state == StRun) && !fetch_bus.redirect_valid;
    assign w_pop  = (r_count != '0) && fetch_bus.inst_ready && !fetch_bus.redirect_valid;

    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_ack && !w_rsp) begin
            w_out_nxt = r_outstanding + CNT_W'(1);
        end else if (!w_ack && w_rsp) begin
            w_out_nxt = r_outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StRun: begin
                if (fetch_bus.redirect_valid && (w_out_nxt != '0)) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (w_out_nxt == '0) begin
                    w_state_nxt = StRun;
                end
            end
            default: w_state_nxt = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_VECTOR;
            r_head_pc     <= RESET_VECTOR;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_outstanding <= w_out_nxt;
            if (fetch_bus.redirect_valid) begin
                r_fetch_pc <= {fetch_bus.redirect_pc[31:2], 2'b00};
                r_head_pc  <= {fetch_bus.redirect_pc[31:2], 2'b00};
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_ack) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_fifo[r_wr_ptr] <= fetch_bus.mem_rsp_data;
                    r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                    r_head_pc <= r_head_pc + 32'd4;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    assign fetch_bus.mem_req_valid = w_req;
    assign fetch_bus.mem_req_addr  = reset ? r_fetch_pc : 32'h0;
    assign fetch_bus.inst_valid    = (r_count != '0);
    assign fetch_bus.inst_data     = r_fifo[r_rd_ptr];
    assign fetch_bus.inst_pc       = reset ? r_head_pc : 32'h0;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (fetch_bus.inst_ready && (r_count == '0) && (r_state == StRun)
                && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (fetch_bus.redirect_valid && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif
endmodule

// File: tb/tb_inst_fetch32.sv
// Scoreboard bench for inst_fetch32: random memory/decode/redirect traffic against an
// epoch-tagged request model; directed phases for backpressure, drain, wrap and reset.
module tb_inst_fetch32;
    localparam int unsigned DEPTH        = 2;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_fetch32_if bus_if ();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    inst_fetch32 #(
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_bus      (bus_if)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: every word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------- driver (memory + decode + execute stand-ins) ----------------
    typedef struct { logic [31:0] addr; int cyc; } drv_t;
    drv_t drv_q[$];
    int cyc = 0;
    int unsigned p_ack = 100, p_rsp = 100, p_ready = 100, p_redir = 0;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc = '0;

    task automatic idle_inputs();
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = '0;
        bus_if.mem_req_ack    = 1'b0;
        bus_if.mem_rsp_valid  = 1'b0;
        bus_if.mem_rsp_data   = '0;
        bus_if.inst_ready     = 1'b0;
    endtask

    task automatic one_cycle();
        @(negedge clk);
        cyc++;
        bus_if.inst_ready = ($urandom_range(99) < p_ready);
        if (force_redir) begin
            bus_if.redirect_valid = 1'b1;
            bus_if.redirect_pc    = force_pc;
            force_redir           = 1'b0;
        end else if ($urandom_range(99) < p_redir) begin
            bus_if.redirect_valid = 1'b1;
            bus_if.redirect_pc    = $urandom_range(1) ? $urandom : (32'hFFFF_FFF0 | $urandom_range(15));
        end else begin
            bus_if.redirect_valid = 1'b0;
            bus_if.redirect_pc    = $urandom;
        end
        if (drv_q.size() != 0 && drv_q[0].cyc < cyc && $urandom_range(99) < p_rsp) begin
            bus_if.mem_rsp_valid = 1'b1;
            bus_if.mem_rsp_data  = mem_word(drv_q[0].addr);
            void'(drv_q.pop_front());
        end else begin
            bus_if.mem_rsp_valid = 1'b0;
            bus_if.mem_rsp_data  = $urandom;
        end
        #1;
        bus_if.mem_req_ack = bus_if.mem_req_valid && ($urandom_range(99) < p_ack);
        if (bus_if.mem_req_ack) drv_q.push_back('{bus_if.mem_req_addr, cyc});
    endtask

    task automatic drain();
        p_ack = 0; p_rsp = 100; p_ready = 100; p_redir = 0;
        repeat (8) one_cycle();
    endtask

    // ---------------- reference model + monitor ----------------
    typedef struct { logic [31:0] addr; int ep; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    pend_t       pend[$];
    ent_t        expq[$];
    int          epoch = 0;
    logic [31:0] exp_fpc = RESET_VECTOR;
    int          n_acks = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;

    always @(negedge clk) begin
        #3;
        if (reset !== 1'b1) begin
            pend.delete();
            expq.delete();
            epoch   = 0;
            exp_fpc = RESET_VECTOR;
            m_stall = '0;
            m_flush = '0;
        end else begin
            bit stale, redir, exp_mrv;
            pend_t p;
            redir   = bus_if.redirect_valid;
            // Older-epoch requests still in flight mean the unit is draining.
            stale   = (pend.size() != 0) && (pend[0].ep != epoch);
            exp_mrv = !redir && !stale && ((pend.size() + expq.size()) < DEPTH);
            chk("mem_req_valid", {31'b0, bus_if.mem_req_valid}, {31'b0, exp_mrv});
            chk("inst_valid", {31'b0, bus_if.inst_valid}, {31'b0, expq.size() != 0});
            if (bus_if.inst_ready && expq.size() == 0 && !stale) m_stall++;
            if (redir) m_flush++;
            if (!redir && bus_if.inst_valid && bus_if.inst_ready && expq.size() != 0) begin
                chk("inst_pc", bus_if.inst_pc, expq[0].pc);
                chk("inst_data", bus_if.inst_data, expq[0].data);
                void'(expq.pop_front());
            end
            if (bus_if.mem_rsp_valid && pend.size() != 0) begin
                p = pend.pop_front();
                if (p.ep == epoch && !redir) expq.push_back('{p.addr, mem_word(p.addr)});
            end
            if (bus_if.mem_req_valid && bus_if.mem_req_ack) begin
                chk("mem_req_addr", bus_if.mem_req_addr, exp_fpc);
                pend.push_back('{exp_fpc, epoch});
                exp_fpc += 32'd4;
                n_acks++;
            end
            if (redir) begin
                expq.delete();
                epoch++;
                exp_fpc = {bus_if.redirect_pc[31:2], 2'b00};
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst mem_req_valid", {31'b0, bus_if.mem_req_valid}, 32'h0);
        chk("rst inst_valid", {31'b0, bus_if.inst_valid}, 32'h0);
        chk("rst mem_req_addr", bus_if.mem_req_addr, 32'h0);
        chk("rst inst_pc", bus_if.inst_pc, 32'h0);
        chk("rst inst_data", bus_if.inst_data, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst perf_stall", perf_stall_cnt, 32'h0);
        chk("rst perf_flush", perf_flush_cnt, 32'h0);
`endif
    endtask

    initial begin
        int n0;
        idle_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;

        // Streaming: every request acked, answered next cycle, decode always ready.
        p_ack = 100; p_rsp = 100; p_ready = 100; p_redir = 0;
        repeat (20) one_cycle();

        // Backpressure: only DEPTH requests may be in flight or buffered.
        drain();
        p_ack = 100; p_rsp = 100; p_ready = 0;
        #3 n0 = n_acks;
        repeat (12) one_cycle();
        #3;
        chk("acks under backpressure", n_acks - n0, DEPTH);
        chk("req stalled by credit", {31'b0, bus_if.mem_req_valid}, 32'h0);
        p_ready = 100;
        repeat (10) one_cycle();

        // Redirect with two requests in flight, misaligned target.
        drain();
        p_ack = 100; p_rsp = 0; p_ready = 100;
        repeat (3) one_cycle();
        force_redir = 1'b1; force_pc = 32'h0000_0103;
        one_cycle();
        p_rsp = 100;
        repeat (10) one_cycle();

        // Redirect coinciding with a response and a ready decode.
        drain();
        p_ack = 100; p_rsp = 0; p_ready = 0;
        repeat (3) one_cycle();
        p_ack = 0; p_rsp = 100;
        one_cycle();
        p_ready = 100;
        force_redir = 1'b1; force_pc = 32'h0000_0200;
        one_cycle();
        p_ack = 100;
        repeat (8) one_cycle();

        // Address wrap at the top of memory.
        drain();
        p_ack = 100; p_rsp = 100; p_ready = 100;
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
        repeat (12) one_cycle();

        // Reset while draining with one response outstanding.
        drain();
        p_ack = 100; p_rsp = 0;
        one_cycle();
        p_ack = 0;
        force_redir = 1'b1; force_pc = 32'h0000_0400;
        one_cycle();
        @(negedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        drv_q.delete();
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        p_ack = 100; p_rsp = 100; p_ready = 100;
        repeat (10) one_cycle();

        // Random traffic.
        for (int blk = 0; blk < 30; blk++) begin
            p_ack   = $urandom_range(100, 30);
            p_rsp   = $urandom_range(100, 30);
            p_ready = $urandom_range(100, 20);
            p_redir = $urandom_range(8);
            repeat (100) one_cycle();
        end

`ifdef FETCH_PERF_EN
        @(negedge clk);
        #2;
        chk("perf_stall_cnt", perf_stall_cnt, m_stall);
        chk("perf_flush_cnt", perf_flush_cnt, m_flush);
`endif
        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
